mux_tree_ccff_cfg: RTL and testbench
====================================

Name: mux_tree_ccff_cfg

Overview:
- Parametrised routing mux tree with an embedded configuration chain. N data inputs feed a 2:1 mux tree of L = clog2(N+1) levels; unused leaves are tied to constant 1.
- Select bits come from an on-block serial shadow register plus an active register, so reconfiguration never glitches the routed output.
- Optional output register. Sits in SB/CB routing tiles and replaces fixed-size mux tree + external config-FF instances.

Parameters:
- N_IN, 14, number of data inputs (2..64).
- L, clog2(N_IN+1), select width / tree depth. Derived; not overridable.
- OUT_REG, 0, 1 = registered output, 0 = combinational output.
- LOAD_CHECK, 1, 1 = a commit is accepted only after at least L shifts.

Ports:
- prog_clk  in  1  single clock for chain, commit and output register.
- prog_rst_n  in  1  synchronous reset, active-low.
- in  in  N_IN  routed data inputs.
- ccff_head  in  1  serial config data in.
- ccff_shift_en  in  1  shift chain one bit this cycle.
- ccff_tail  out  1  serial config data out (= shadow[0]).
- cfg_commit  in  1  copy shadow to active.
- cfg_active  out  L  current active select code.
- cfg_valid  out  1  active holds a committed, fully loaded code.
- cfg_err  out  1  one-cycle pulse when a commit is rejected.
- out  out  1  mux output.

Behaviour:
- Reset (prog_rst_n=0 at an edge):
  - shadow=0, active=0, shift count=0.
  - cfg_valid=0, cfg_err=0, ccff_tail=0.
  - out=1 when OUT_REG=1. When OUT_REG=0, out follows the combinational decode of active=0.
  - Reset overrides shift and commit in the same cycle.
- Select decode for active code c:
  - in[i] is selected when c == 2^L-1-i.
  - Codes below 2^L-N_IN select constant 1.
  - Example, N_IN=14 (L=4): c=15 -> in[0], c=14 -> in[1], c=2 -> in[13], c=0/1 -> 1.
  - Tree structure: level k uses active[k-1], A1 chosen when the bit is 1. Leaves are paired (in[2j], in[2j+1]) at level 1; the const-1 pad sits at the highest-index leaves.
- Shift, when ccff_shift_en=1:
  - shadow[L-1] <= ccff_head; shadow[k] <= shadow[k+1].
  - ccff_tail is the shadow[0] flop.
  - After L shifts the first bit shifted in is in shadow[0] (LSB first).
  - Shift count saturates at L.
- Commit, when cfg_commit=1:
  - If LOAD_CHECK=0 or count==L: active <= shadow, cfg_valid <= 1, count <= 0.
  - Otherwise (count<L): active and cfg_valid unchanged, cfg_err=1 for one cycle.
- Commit and shift in the same cycle:
  - active takes the pre-shift shadow.
  - The shift still occurs.
  - The count result is 1 if the commit is accepted; otherwise it is the incremented count.
- Active changes only on an accepted commit. Shifting alone never alters out.
- Latency:
  - OUT_REG=0: out reflects in and active combinationally; a new code is visible in the cycle after the commit edge.
  - OUT_REG=1: out registered once more. Data-to-out latency is 1 cycle; commit-to-out is 2 cycles.
- Reset mid-load discards partial shadow contents and the count; the next commit requires a fresh L shifts.
- Chain cascading: ccff_tail feeds the next block's ccff_head. Total chain length = sum of L over the chain.

Decomposition:
- Shared package cfg_pkg:
  - clog2 function.
  - MUX_CONST_PAD = 1'b1.
  - Helper function sel_code(i, N) = 2^L-1-i, for use by benches and bitstream tools.
- Sub-module: mux_tree_core, purely combinational and parametrised on N_IN. Its generate-built MUX2 levels with const1 padding, plus buf4 on the output, are reused by future sizes.
- The top level holds the shadow/active registers, the counter and the output register.

Test Plan:
- Reset: hold prog_rst_n=0 for 2 cycles with shift/commit toggling -> active=0, cfg_valid=0, ccff_tail=0, out=1 (N_IN=14).
- Load and commit: shift 4 bits 1,0,1,1 (LSB first, code 13), then commit; in[2]=0, others 1 -> cfg_active=13, cfg_valid=1, out=0 next cycle; toggling in[2] toggles out.
- Early commit: 3 shifts then commit -> cfg_err pulses 1 cycle, active unchanged, cfg_valid unchanged; a 4th shift then commit is accepted.
- Concurrent commit and shift: with shadow=15 and count=4, assert shift(head=0) and commit together -> active=15, shadow=7, count=1.
- Pad codes and cascade:
  - Commit codes 0 and 1 with all inputs 0 -> out=1.
  - Two chained instances loaded with 8 bits -> each takes its own nibble.
- OUT_REG=1: after commit of code 15 with in[0] 0->1 at cycle t -> out=1 at t+1; out=1 while in reset.

Source files
------------

// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared sizing helpers and constants for config-chain mux trees.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_pkg;

    localparam logic MUX_CONST_PAD = 1'b1;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Select code that routes data input i of an n-input tree to the output.
    function automatic int sel_code(input int i, input int n);
        return (1 << clog2(n + 1)) - 1 - i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_tree_core.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_core
// Description : Combinational 2:1 mux tree with constant-1 padded leaves.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_core
    import cfg_pkg::*;
#(
    parameter int N_IN = 14
) (
    input  logic [N_IN-1:0]          in,
    input  logic [clog2(N_IN+1)-1:0] sel,
    output logic                     out
);

    localparam int L        = clog2(N_IN + 1);
    localparam int c_n_leaf = 1 << L;

    // Level 0 holds the leaves; level k has 2^(L-k) nodes steered by sel[k-1].
    for (genvar k = 0; k <= L; k++) begin : g_level
        logic [(1 << (L - k))-1:0] w_lvl;
        if (k == 0) begin : g_leaves
            assign w_lvl = {{(c_n_leaf - N_IN){MUX_CONST_PAD}}, in};
        end else begin : g_row
            for (genvar j = 0; j < (1 << (L - k)); j++) begin : g_mux2
                assign w_lvl[j] = sel[k-1] ? g_level[k-1].w_lvl[2*j]
                                           : g_level[k-1].w_lvl[2*j+1];
            end
        end
    end

    logic w_buf4;
    assign w_buf4 = g_level[L].w_lvl[0];
    assign out    = w_buf4;

endmodule
`default_nettype wire

// File: rtl/mux_tree_ccff_cfg.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_ccff_cfg
// Description : Routing mux tree with serial shadow/active select registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_ccff_cfg
    import cfg_pkg::*;
#(
    parameter int N_IN       = 14,
    parameter int OUT_REG    = 0,
    parameter int LOAD_CHECK = 1
) (
    input  logic                     prog_clk,
    input  logic                     prog_rst_n,
    input  logic [N_IN-1:0]          in,
    input  logic                     ccff_head,
    input  logic                     ccff_shift_en,
    output logic                     ccff_tail,
    input  logic                     cfg_commit,
    output logic [clog2(N_IN+1)-1:0] cfg_active,
    output logic                     cfg_valid,
    output logic                     cfg_err,
    output logic                     out
);

    localparam int                 L          = clog2(N_IN + 1);
    localparam int                 c_cnt_w    = clog2(L + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(L);

    logic [L-1:0]       r_shadow;
    logic [L-1:0]       r_active;
    logic [c_cnt_w-1:0] r_count;
    logic               r_valid;
    logic               r_err;
    logic               w_accept;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               w_mux;

    assign w_accept = cfg_commit && ((LOAD_CHECK == 0) || (r_count == c_cnt_full));

    // An accepted commit restarts the count, crediting a same-cycle shift.
    always_comb begin
        w_count_nxt = r_count;
        if (w_accept) begin
            w_count_nxt = ccff_shift_en ? c_cnt_w'(1) : '0;
        end else if (ccff_shift_en && (r_count != c_cnt_full)) begin
            w_count_nxt = r_count + c_cnt_w'(1);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err   <= cfg_commit & ~w_accept;
            r_count <= w_count_nxt;
            if (ccff_shift_en) begin
                r_shadow <= {ccff_head, r_shadow[L-1:1]};
            end
            if (w_accept) begin
                r_active <= r_shadow;
                r_valid  <= 1'b1;
            end
        end
    end

    mux_tree_core #(
        .N_IN (N_IN)
    ) u_core (
        .in  (in),
        .sel (r_active),
        .out (w_mux)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic r_out;
        always_ff @(posedge prog_clk) begin
            if (!prog_rst_n) begin
                r_out <= 1'b1;
            end else begin
                r_out <= w_mux;
            end
        end
        assign out = r_out;
    end else begin : g_out_comb
        assign out = w_mux;
    end

    assign ccff_tail  = r_shadow[0];
    assign cfg_active = r_active;
    assign cfg_valid  = r_valid;
    assign cfg_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_ccff_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_tree_ccff_cfg
// Description : Two cascaded blocks (combinational + registered output) checked
//               against a bit-history reference model through a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_tree_ccff_cfg;
    import cfg_pkg::*;

    localparam int N = 14;
    localparam int L = 4;

    typedef struct {
        logic [L-1:0] act_a;
        logic [L-1:0] act_b;
        logic         valid;
        logic         err;
        logic         tail_a;
        logic         tail_b;
        logic         out_a;
        logic         out_b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, head, shift_en, commit;
    logic [N-1:0] din;
    logic         tail_a, tail_b, valid_a, valid_b, err_a, err_b, out_a, out_b;
    logic [L-1:0] act_a, act_b;

    always #5 clk = ~clk;

    mux_tree_ccff_cfg #(.N_IN(N), .OUT_REG(0), .LOAD_CHECK(1)) u_dut_a (
        .prog_clk(clk), .prog_rst_n(rst_n), .in(din),
        .ccff_head(head), .ccff_shift_en(shift_en), .ccff_tail(tail_a),
        .cfg_commit(commit), .cfg_active(act_a), .cfg_valid(valid_a),
        .cfg_err(err_a), .out(out_a)
    );

    mux_tree_ccff_cfg #(.N_IN(N), .OUT_REG(1), .LOAD_CHECK(1)) u_dut_b (
        .prog_clk(clk), .prog_rst_n(rst_n), .in(din),
        .ccff_head(tail_a), .ccff_shift_en(shift_en), .ccff_tail(tail_b),
        .cfg_commit(commit), .cfg_active(act_b), .cfg_valid(valid_b),
        .cfg_err(err_b), .out(out_b)
    );

    // Reference model: the last 8 bits that entered the chain, newest at index 7.
    bit           hist[$];
    int           m_cnt;
    logic [L-1:0] m_act_a, m_act_b;
    logic         m_valid, m_err, m_out_b;
    exp_t         sb[$];
    int           n_cmp  = 0;
    int           n_fail = 0;

    function automatic logic route(input logic [L-1:0] code, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (int'(code) == sel_code(i, N)) return v[i];
        end
        return 1'b1;
    endfunction

    function automatic logic [L-1:0] code_at(input int base);
        return {hist[base+3], hist[base+2], hist[base+1], hist[base]};
    endfunction

    task automatic model_edge();
        logic acc;
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < 8; i++) hist.push_back(1'b0);
            m_cnt   = 0;
            m_act_a = '0;
            m_act_b = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_out_b = 1'b1;
        end else begin
            m_out_b = route(m_act_b, din);
            acc     = commit && (m_cnt == L);
            m_err   = commit && !acc;
            if (acc) begin
                m_act_a = code_at(4);
                m_act_b = code_at(0);
                m_valid = 1'b1;
            end
            if (shift_en) begin
                hist.push_back(head);
                void'(hist.pop_front());
            end
            if (acc) m_cnt = shift_en ? 1 : 0;
            else if (shift_en && m_cnt < L) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic cycle(input logic r, input logic h, input logic s, input logic c,
                         input logic [N-1:0] v);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst_n = r; head = h; shift_en = s; commit = c; din = v;
        e.act_a  = m_act_a;
        e.act_b  = m_act_b;
        e.valid  = m_valid;
        e.err    = m_err;
        e.tail_a = hist[4];
        e.tail_b = hist[0];
        e.out_a  = route(m_act_a, din);
        e.out_b  = m_out_b;
        sb.push_back(e);
    endtask

    task automatic shift_bits(input logic [7:0] bits, input int n, input logic [N-1:0] v);
        for (int i = 0; i < n; i++) cycle(1'b1, bits[i], 1'b1, 1'b0, v);
    endtask

    function automatic void check(input string name, input logic [7:0] got,
                                  input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cfg_active_a", 8'(act_a), 8'(e.act_a));
                check("cfg_active_b", 8'(act_b), 8'(e.act_b));
                check("cfg_valid_a", 8'(valid_a), 8'(e.valid));
                check("cfg_valid_b", 8'(valid_b), 8'(e.valid));
                check("cfg_err_a", 8'(err_a), 8'(e.err));
                check("cfg_err_b", 8'(err_b), 8'(e.err));
                check("ccff_tail_a", 8'(tail_a), 8'(e.tail_a));
                check("ccff_tail_b", 8'(tail_b), 8'(e.tail_b));
                check("out_a", 8'(out_a), 8'(e.out_a));
                check("out_b", 8'(out_b), 8'(e.out_b));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        logic [N-1:0] all1, v;
        all1 = '1;
        rst_n = 1'b0; head = 1'b0; shift_en = 1'b0; commit = 1'b0; din = all1;

        // Reset held with shift/commit toggling
        cycle(1'b0, 1'b1, 1'b1, 1'b1, all1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, all1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, all1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, all1);

        // Load code 13 LSB first, route in[2]
        v = all1;
        v[2] = 1'b0;
        shift_bits(8'b0000_1101, 4, v);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, v);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, v);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, all1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, v);

        // Early commit rejected, then accepted after the 4th shift
        shift_bits(8'b0000_0110, 3, v);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, v);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, v);
        shift_bits(8'b0000_0000, 1, v);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, v);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, v);

        // Concurrent shift and commit: active gets pre-shift shadow, count restarts at 1
        shift_bits(8'b0000_1111, 4, all1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, all1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, all1);
        shift_bits(8'b0000_0101, 3, all1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, all1);

        // Pad codes 0 and 1 with all inputs low
        shift_bits(8'b0000_0000, 4, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        shift_bits(8'b0000_0001, 4, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Cascade: 8 bits split into one nibble per block
        shift_bits(8'b1010_0011, 8, 14'h2aaa);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 14'h2aaa);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h1555);

        // Registered output: code 15 on both, in[0] rising
        shift_bits(8'hff, 8, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0001);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0001);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Reset mid-load, then a commit without a fresh full load
        cycle(1'b1, 1'b0, 1'b0, 1'b0, all1);
        shift_bits(8'b0000_0011, 2, all1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, all1);
        shift_bits(8'b0000_0011, 2, all1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, all1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0), N'($urandom));
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, all1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
